// File: rtl/cipher_pkg.sv
// cipher_pkg: shared widths and types for the keystream
// byte cipher and its key FIFO.
package cipher_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_IDX_W = 3;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/ks_key_fifo.sv
// ks_key_fifo: small synchronous FIFO of packed key bytes.
// A push into a full FIFO is accepted only if a pop coincides.
module ks_key_fifo
  import cipher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head_data,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  byte_t       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = mem[rd_ptr[AW-1:0]];

  // Key storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read and write pointers with a wrap bit for full/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ks_xor_byte_cipher.sv
// ks_xor_byte_cipher: packs keystream bits MSB-first into key
// bytes and XORs each with one input byte (encrypt == decrypt).
module ks_xor_byte_cipher
  import cipher_pkg::*;
#(
  parameter int KEY_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ks_bit,
  input  logic             ks_valid,
  input  logic [7:0]       pt_data,
  input  logic             pt_valid,
  output logic             pt_ready,
  output logic [7:0]       ct_data,
  output logic             ct_valid,
  input  logic             ct_ready,
  input  logic             clr_ovr,
  output logic             ks_overrun,
  output logic [CNT_W-1:0] byte_count
);

  logic [BIT_IDX_W-1:0] bit_cnt;
  byte_t                shreg;
  byte_t                key_byte;
  byte_t                head;
  logic                 byte_done;
  logic                 empty;
  logic                 full;
  logic                 xfer;
  logic                 ovr_set;

  // Completed byte = seven earlier bits plus the current one.
  assign key_byte  = {shreg[BYTE_W-2:0], ks_bit};
  assign byte_done = ks_valid && (bit_cnt == '1);

  // Ready depends only on registered state and ct_ready.
  assign pt_ready = !empty && (!ct_valid || ct_ready);
  assign xfer     = pt_valid && pt_ready;

  // A pop on the same edge frees the slot, so no drop then.
  assign ovr_set = byte_done && full && !xfer;

  ks_key_fifo #(
    .DEPTH(KEY_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (byte_done),
    .push_data(key_byte),
    .pop      (xfer),
    .head_data(head),
    .empty    (empty),
    .full     (full)
  );

  // Bit packer: shift and count only on valid keystream bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (ks_valid) begin
      shreg   <= key_byte;
      bit_cnt <= bit_cnt + BIT_IDX_W'(1);
    end
  end

  // Output register with hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct_data    <= '0;
      ct_valid   <= 1'b0;
      byte_count <= '0;
    end else if (xfer) begin
      ct_data    <= pt_data ^ head;
      ct_valid   <= 1'b1;
      byte_count <= byte_count + CNT_W'(1);
    end else if (ct_valid && ct_ready) begin
      ct_valid   <= 1'b0;
    end
  end

  // Sticky overrun flag; a new drop wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_overrun <= 1'b0;
    end else if (ovr_set) begin
      ks_overrun <= 1'b1;
    end else if (clr_ovr) begin
      ks_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ks_xor_byte_cipher.sv
// tb_ks_xor_byte_cipher: random and directed stimulus against
// a queue-based reference model, plus an A->B round trip.
module tb_ks_xor_byte_cipher;
  import cipher_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ks_bit = 1'b0;
  logic          ks_valid = 1'b0;
  logic [7:0]    pt_data = '0;
  logic          pt_valid = 1'b0;
  logic          ct_ready = 1'b0;
  logic          clr_ovr = 1'b0;
  logic          rt = 1'b0;

  logic          a_pt_ready;
  logic [7:0]    a_ct_data;
  logic          a_ct_valid;
  logic          a_ct_ready;
  logic          a_ovr;
  logic [CW-1:0] a_cnt;

  logic          b_pt_ready;
  logic [7:0]    b_ct_data;
  logic          b_ct_valid;
  logic          b_ovr;
  logic [CW-1:0] b_cnt;

  always #5 clk = ~clk;

  assign a_ct_ready = rt ? b_pt_ready : ct_ready;

  ks_xor_byte_cipher #(
    .KEY_DEPTH(DEPTH),
    .CNT_W    (CW)
  ) u_a (
    .clk       (clk),
    .rst       (rst),
    .ks_bit    (ks_bit),
    .ks_valid  (ks_valid),
    .pt_data   (pt_data),
    .pt_valid  (pt_valid),
    .pt_ready  (a_pt_ready),
    .ct_data   (a_ct_data),
    .ct_valid  (a_ct_valid),
    .ct_ready  (a_ct_ready),
    .clr_ovr   (clr_ovr),
    .ks_overrun(a_ovr),
    .byte_count(a_cnt)
  );

  ks_xor_byte_cipher #(
    .KEY_DEPTH(DEPTH),
    .CNT_W    (CW)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .ks_bit    (ks_bit),
    .ks_valid  (ks_valid),
    .pt_data   (a_ct_data),
    .pt_valid  (a_ct_valid),
    .pt_ready  (b_pt_ready),
    .ct_data   (b_ct_data),
    .ct_valid  (b_ct_valid),
    .ct_ready  (1'b1),
    .clr_ovr   (1'b0),
    .ks_overrun(b_ovr),
    .byte_count(b_cnt)
  );

  int errs = 0;
  int checks = 0;

  byte_t m_q[$];
  int    m_acc;
  int    m_nb;
  logic  m_cv;
  byte_t m_ct;
  logic  m_ovr;
  int    m_cnt;
  byte_t pt_list[$];
  byte_t rt_exp[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    rt_exp.delete();
    m_acc = 0;
    m_nb  = 0;
    m_cv  = 1'b0;
    m_ct  = '0;
    m_ovr = 1'b0;
    m_cnt = 0;
  endtask

  function automatic logic m_ready(logic cr);
    return (m_q.size() > 0) && (!m_cv || cr);
  endfunction

  // One clock: check DUT against model, then advance model.
  task automatic step();
    logic  cr;
    logic  xfer;
    logic  ovs;
    byte_t k;
    #1;
    cr = a_ct_ready;
    chk("pt_ready", a_pt_ready, m_ready(cr));
    chk("ct_valid", a_ct_valid, m_cv);
    chk("ct_data", a_ct_data, m_ct);
    chk("overrun", a_ovr, m_ovr);
    chk("count", a_cnt, m_cnt);
    if (rt && b_ct_valid) begin
      chk("rt_pending", rt_exp.size() != 0, 1);
      if (rt_exp.size() != 0) begin
        chk("rt_data", b_ct_data, rt_exp.pop_front());
      end
    end
    xfer = pt_valid && m_ready(cr);
    @(posedge clk);
    if (xfer) begin
      k     = m_q.pop_front();
      m_ct  = pt_data ^ k;
      m_cv  = 1'b1;
      m_cnt = (m_cnt + 1) % (1 << CW);
      if (rt) begin
        rt_exp.push_back(pt_data);
        void'(pt_list.pop_front());
      end
    end else if (m_cv && cr) begin
      m_cv = 1'b0;
    end
    ovs = 1'b0;
    if (ks_valid) begin
      m_acc = (m_acc * 2 + int'(ks_bit)) % 256;
      m_nb++;
      if (m_nb == 8) begin
        m_nb = 0;
        if (m_q.size() < DEPTH) m_q.push_back(byte_t'(m_acc));
        else ovs = 1'b1;
      end
    end
    if (ovs) m_ovr = 1'b1;
    else if (clr_ovr) m_ovr = 1'b0;
    @(negedge clk);
  endtask

  // Assert reset a few ns after an edge, release on negedge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_ct_valid", a_ct_valid, 0);
    chk("rst_ct_data", a_ct_data, 0);
    chk("rst_pt_ready", a_pt_ready, 0);
    chk("rst_overrun", a_ovr, 0);
    chk("rst_count", a_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle();
    ks_valid = 1'b0;
    pt_valid = 1'b0;
    clr_ovr  = 1'b0;
  endtask

  initial begin
    byte_t c3;
    m_reset();

    // Reset, then seven keystream bits: no key byte yet.
    do_reset();
    ks_valid = 1'b1;
    repeat (7) begin
      ks_bit = 1'($urandom);
      step();
    end
    chk("rst_no_push", a_pt_ready, 0);

    // 1,0,1,0,... packs to 0xAA; 0x55 ^ 0xAA = 0xFF.
    do_reset();
    ct_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ks_valid = 1'b1;
      ks_bit   = (i % 2 == 0);
      step();
    end
    ks_valid = 1'b0;
    pt_data  = 8'h55;
    pt_valid = 1'b1;
    step();
    chk("xor_basic", a_ct_data, 8'hFF);
    chk("xor_valid", a_ct_valid, 1);
    chk("xor_count", a_cnt, 1);
    pt_valid = 1'b0;
    step();

    // Backpressure: output holds, no pop while stalled.
    do_reset();
    ks_valid = 1'b1;
    repeat (24) begin
      ks_bit = 1'($urandom);
      step();
    end
    ks_valid = 1'b0;
    ct_ready = 1'b1;
    pt_valid = 1'b1;
    pt_data  = 8'($urandom);
    step();
    ct_ready = 1'b0;
    repeat (5) begin
      pt_data = 8'($urandom);
      step();
      chk("bp_ready", a_pt_ready, 0);
    end
    ct_ready = 1'b1;
    repeat (4) begin
      pt_data = 8'($urandom);
      step();
    end
    idle();
    step();

    // Overrun: five bytes into a four-entry FIFO.
    do_reset();
    ks_valid = 1'b1;
    repeat (8 * (DEPTH + 1)) begin
      ks_bit = 1'($urandom);
      step();
    end
    chk("ovr_set", a_ovr, 1);
    ks_valid = 1'b0;
    clr_ovr  = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_clr", a_ovr, 0);
    pt_valid = 1'b1;
    repeat (6) begin
      pt_data = 8'($urandom);
      step();
    end
    idle();
    step();

    // Bubbles between the bits of 0xC3.
    do_reset();
    c3 = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      ks_valid = 1'b1;
      ks_bit   = c3[i];
      step();
      repeat ($urandom_range(2, 0)) begin
        ks_valid = 1'b0;
        ks_bit   = 1'($urandom);
        step();
      end
    end
    ks_valid = 1'b0;
    pt_data  = 8'hC3;
    pt_valid = 1'b1;
    step();
    chk("gap_ct", a_ct_data, 8'h00);
    idle();
    step();

    // Random traffic: sparse then dense input.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ks_bit   = 1'($urandom);
      ks_valid = ($urandom_range(3, 0) != 0);
      pt_data  = 8'($urandom);
      pt_valid = (i < 1500) ? ($urandom_range(7, 0) == 0)
                            : ($urandom_range(3, 0) != 0);
      ct_ready = ($urandom_range(2, 0) != 0);
      clr_ovr  = ($urandom_range(15, 0) == 0);
      step();
    end
    idle();
    ct_ready = 1'b1;
    step();

    // Round trip: B decrypts A's output with the same keystream.
    do_reset();
    rt = 1'b1;
    pt_list = '{8'h00, 8'h3C, 8'hFF, 8'h81};
    for (int i = 0; i < 400; i++) begin
      ks_bit   = 1'($urandom);
      ks_valid = 1'($urandom);
      pt_valid = (pt_list.size() > 0);
      pt_data  = (pt_list.size() > 0) ? pt_list[0] : 8'h00;
      step();
      if (pt_list.size() == 0 && rt_exp.size() == 0) break;
    end
    chk("rt_done", pt_list.size() + rt_exp.size(), 0);
    chk("rt_a_cnt", a_cnt, 4);
    chk("rt_b_cnt", b_cnt, 4);
    rt = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ks_xor_byte_cipher.md
Name: ks_xor_byte_cipher

Overview:
Downstream consumer of the free-running LFSR keystream bit. It packs keystream bits into key bytes, buffers them in a small FIFO, and XORs each with one plaintext byte, producing ciphertext on a valid/ready stream. Encryption and decryption are the same operation. It sits between the LFSR keystream generator and the byte-wide data path.

Parameters:
KEY_DEPTH, 4, key-byte FIFO depth in entries; power of 2, minimum 2.
CNT_W, 16, width of the processed-byte counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
ks_bit  in  1  keystream bit, the LFSR MSB output.
ks_valid  in  1  ks_bit is valid this cycle; tie high for a free-running LFSR.
pt_data  in  8  input byte (plaintext or ciphertext).
pt_valid  in  1  pt_data is valid.
pt_ready  out  1  block accepts pt_data this cycle.
ct_data  out  8  output byte, equal to pt_data XOR key byte.
ct_valid  out  1  ct_data is valid.
ct_ready  in  1  sink accepts ct_data.
clr_ovr  in  1  synchronous clear of ks_overrun.
ks_overrun  out  1  sticky flag: a completed key byte was dropped because the FIFO was full.
byte_count  out  CNT_W  number of bytes emitted, modulo 2^CNT_W.

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. Under reset the bit counter = 0, packer shift register = 0x00, FIFO empty, ct_valid = 0, ct_data = 0x00, ks_overrun = 0, byte_count = 0, and pt_ready = 0 because the FIFO is empty.
- Packer:
  - On each clk edge with ks_valid = 1, shift MSB-first: the first bit of a byte lands in key[7], the eighth in key[0].
  - A 3-bit counter tracks bit position and wraps from 7 to 0.
  - Cycles with ks_valid = 0 neither shift nor count.
- Key push:
  - On the edge that captures the 8th bit, the completed byte (prior 7 bits plus the current ks_bit) is written into the FIFO.
  - That byte is visible at the FIFO head on the next cycle.
- FIFO full on push: the byte is discarded and ks_overrun sets on the same edge. The packer keeps running, so the next byte starts cleanly.
- Push and pop on the same edge while full: the push is accepted and no overrun occurs.
- ks_overrun clearing:
  - Cleared by clr_ovr on an edge where no overrun occurs.
  - If set and clear coincide, set wins.
- pt_ready = FIFO not empty AND (ct_valid = 0 OR ct_ready = 1). This is combinational from registered state plus ct_ready.
- Transfer (pt_valid AND pt_ready), on that edge:
  - ct_data <= pt_data XOR FIFO head.
  - FIFO pops.
  - ct_valid <= 1.
  - byte_count increments.
  - Latency is 1 cycle from input acceptance to ct_valid.
- Output without a new transfer:
  - If ct_valid = 1 and ct_ready = 1 with no new transfer, ct_valid <= 0.
  - While ct_valid = 1 and ct_ready = 0, ct_data and ct_valid hold stable.
- Throughput: with back-to-back readiness, one byte per cycle while key bytes are buffered. Sustained rate is bounded to 1 byte per 8 ks_valid cycles.
- No combinational path exists from pt_valid to pt_ready.
- byte_count wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: all state clears immediately, including partially packed bits and buffered key bytes. The peer end must be reset in the same cycle to keep the keystreams aligned.

Decomposition:
- Package cipher_pkg holds:
  - constant BYTE_W = 8;
  - constant BIT_IDX_W = 3;
  - typedef byte_t (logic [7:0]).
- One sub-module: ks_key_fifo, a synchronous FIFO with parameters DEPTH and width BYTE_W.
  - Ports: push, push_data, pop, head_data, empty, full.
  - Simultaneous push and pop when full is allowed.
  - All packer, handshake and counter logic stays in the top module.

Test Plan:
- Reset check: assert rst mid-cycle, release it, then drive ks_valid = 1 for 7 cycles -> all outputs are at their reset values, pt_ready stays 0, and no FIFO push occurs.
- Basic XOR: keystream bits 1,0,1,0,1,0,1,0 -> key 0xAA; send pt_data = 0x55 with pt_valid = 1 -> ct_data = 0xFF with ct_valid one cycle after acceptance; byte_count = 1.
- Round trip: two instances fed the same ks_bit stream; instance A's ct feeds instance B's pt; plaintext 0x00, 0x3C, 0xFF, 0x81 -> B outputs the same bytes; both byte_count = 4.
- Backpressure: hold ct_ready = 0 for 5 cycles with ct_valid = 1 -> ct_data stays stable, pt_ready = 0, and no extra pop; release -> data drains in order at 1 byte/cycle.
- Overrun: pt_valid = 0 and ks_valid = 1 for 8 × (KEY_DEPTH + 1) = 40 cycles -> FIFO holds 4 bytes, ks_overrun = 1 after cycle 40; pulse clr_ovr -> ks_overrun = 0.
- ks_valid gaps: insert ks_valid = 0 bubbles between bits of 0xC3 -> key byte is still 0xC3 and pt 0xC3 yields ct 0x00.
